// File: rtl/address_latch_burst_pkg.sv
// Shared types and helpers for the address latch: load-select encoding and clog2.
package address_latch_pkg;

  typedef enum logic [1:0] {
    LD_NONE     = 2'd0,
    LD_PAR      = 2'd1,
    LD_SER_DONE = 2'd2,
    LD_INC      = 2'd3
  } ld_sel_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/address_latch_burst_if.sv
// Bus between the SPI shift/edge logic (master) and the address latch (slave).
interface address_latch_burst_if
  import address_latch_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] addressIn;
  logic             writeEnable;
  logic             serialIn;
  logic             shiftEnable;
  logic             increment;
  logic [WIDTH-1:0] addressOut;
  logic             addressValid;
  logic [CW-1:0]    bitCount;
  logic             busy;
  logic             wrapped;

  modport master (
    output addressIn, writeEnable, serialIn, shiftEnable, increment,
    input  addressOut, addressValid, bitCount, busy, wrapped
  );

  modport slave (
    input  addressIn, writeEnable, serialIn, shiftEnable, increment,
    output addressOut, addressValid, bitCount, busy, wrapped
  );
endinterface

// File: rtl/address_latch_burst_collector.sv
// Serial frame collector: shadow shift register (MSB first) and bit counter.
module serial_addr_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic             done_o,
  output logic             first_o,
  output logic [WIDTH-1:0] word_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-2:0] shadow_q, shadow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_o   = 1'b0;
    first_o  = 1'b0;
    word_o   = {shadow_q, bit_i};
    if (abort_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (shift_i) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        done_o   = 1'b1;
        shadow_d = '0;
        cnt_d    = '0;
      end else begin
        first_o  = (cnt_q == '0);
        shadow_d = word_o[WIDTH-2:0];
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/address_latch_burst.sv
// Address latch with parallel/serial load and wrapping auto-increment for burst access.
module address_latch_burst
  import address_latch_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WRAP_LIMIT = 2**WIDTH - 1,
  parameter bit          AUTO_INC   = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  address_latch_burst_if.slave bus
);
  localparam int unsigned CW = clog2(WIDTH + 1);

  if (WIDTH < 2) begin : g_width_check
    $error("address_latch_burst: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             ser_done, ser_first;
  logic [WIDTH-1:0] ser_word;
  logic [CW-1:0]    ser_count;
  ld_sel_e          sel;

  serial_addr_collector #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_collector (
    .clk     (clk),
    .reset   (reset),
    .abort_i (bus.writeEnable),
    .shift_i (bus.shiftEnable),
    .bit_i   (bus.serialIn),
    .done_o  (ser_done),
    .first_o (ser_first),
    .word_o  (ser_word),
    .count_o (ser_count)
  );

  always_comb begin
    if (bus.writeEnable)                        sel = LD_PAR;
    else if (ser_done)                          sel = LD_SER_DONE;
    else if (bus.increment && AUTO_INC && valid_q) sel = LD_INC;
    else                                        sel = LD_NONE;
  end

  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    unique case (sel)
      LD_PAR: begin
        addr_d  = bus.addressIn;
        valid_d = 1'b1;
      end
      LD_SER_DONE: begin
        addr_d  = ser_word;
        valid_d = 1'b1;
      end
      LD_INC: begin
        // Out-of-range addresses are treated as at the limit and wrap too.
        if (addr_q >= WIDTH'(WRAP_LIMIT)) begin
          addr_d = '0;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
    if (ser_first) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.addressOut   = addr_q;
  assign bus.addressValid = valid_q;
  assign bus.bitCount     = ser_count;
  assign bus.busy         = (ser_count != '0);
  assign bus.wrapped      = wrap_q;
endmodule
